hall_conditioner: RTL and testbench
===================================

Name: hall_conditioner

Overview:
- Conditions the three raw Hall-effect inputs of one BLDC motor before they reach the phase/commutation driver.
- Synchronizes and glitch-filters the Hall inputs, and rejects illegal codes.
- Decodes rotation direction and keeps a signed position count.
- Measures commutation period in clocks for speed estimation.
- Sits between the Hall sensor pins and the phase driver's hall input; position and period also go to the host-side register interface.

Parameters:
FILTER_CYCLES, 16, consecutive stable clocks required before a new synchronized code is accepted (legal range 1..255)
PERIOD_WIDTH, 16, width of the step-period counter and the period output
COUNT_WIDTH, 16, width of the position counter (two's complement)

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
hall_raw  in  3  unsynchronized Hall sensor pins {C,B,A}
hall  out  3  last accepted legal Hall code; feeds the phase driver
hall_valid  out  1  hall holds a legal code that is current (not faulted)
hall_fault  out  1  last accepted code was 000 or 111
step  out  1  one-clock pulse on each adjacent legal transition
skip  out  1  one-clock pulse on a non-adjacent legal transition
dir  out  1  1 = forward, 0 = reverse; direction of the last step
position  out  COUNT_WIDTH  signed step count; +1 forward, -1 reverse; wraps modulo 2^COUNT_WIDTH
period  out  PERIOD_WIDTH  clocks between the last two step pulses
period_valid  out  1  period holds a real measurement
stalled  out  1  step-interval counter saturated

Behaviour:
- Reset (async, any time, including mid-filter): all outputs, the synchronizers, the filter counter and the period counter go to 0; the FSM enters INIT.
- Synchronization: hall_raw passes through 2 flops, giving sync code s.
- Filter:
  - A candidate register and a stability counter track s. Any change of s reloads the candidate and clears the counter.
  - When the candidate has been equal to s for FILTER_CYCLES consecutive clocks, the candidate is accepted for one clock.
  - The same code is not re-accepted while it stays unchanged.
  - Latency from a hall_raw change to the registered outputs is FILTER_CYCLES+3 clocks.
  - A pulse shorter than FILTER_CYCLES clocks produces no acceptance.
- Forward sequence, cyclic: 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001. Reverse is the same sequence traversed backwards.
- FSM states:
  - INIT: legal accepted code -> load hall, hall_valid=1, go to TRACK; no step is issued. Illegal code -> go to FAULT.
  - TRACK: accepted code is the forward neighbour of hall -> step=1, dir=1, position+1. Reverse neighbour -> step=1, dir=0, position-1. Distance 2 or 3 -> skip=1, hall updated, position and dir unchanged. Illegal code -> go to FAULT.
  - FAULT: hall_fault=1, hall_valid=0, hall keeps the last legal code, period_valid=0. A legal accepted code -> hall_fault=0, then behaves exactly as INIT (reload, no step).
- Period measurement:
  - The interval counter increments every clock in TRACK and saturates at 2^PERIOD_WIDTH-1.
  - On step: period <= counter+1 and counter <= 0. period_valid is set only if a previous step occurred in this TRACK episode and the counter was not saturated; otherwise period_valid=0.
  - Saturation sets stalled=1 and clears period_valid. The next step clears stalled but yields period_valid=0.
  - A skip resets the counter, clears period_valid and does not update period.
  - A direction reversal is a normal step; the period is still measured.
- step and skip are never asserted in the same clock. All outputs are registered.

Optional Feature:
HALL_FILTER_EN
- Defined: glitch filter present as described; latency FILTER_CYCLES+3 clocks.
- Undefined: filter removed; every change of s is accepted on the next edge; latency 3 clocks; FILTER_CYCLES is ignored.

Test Plan:
- Reset, then hall_raw=001 held -> at FILTER_CYCLES+3 clocks: hall=001, hall_valid=1, step=0, position=0.
- From 001, apply the forward sequence 011,010,110,100,101,001 at 10000-clock intervals -> six step pulses with dir=1 and position=6; from the 2nd step on, period=10000 and period_valid=1.
- From 011, apply 001 then 101 -> dir=0, position decrements by 2 total.
- 5-clock pulse 001->011->001 (FILTER_CYCLES=16) -> no step, hall stays 001. Without HALL_FILTER_EN, the same pulse gives a step +1 then -1.
- From 010, apply 111 -> hall_fault=1, hall_valid=0, hall=010. Then apply 110 -> hall=110, hall_valid=1, no step, position unchanged.
- PERIOD_WIDTH=8, hold the code for 300 clocks -> stalled=1 after 255 clocks, period_valid=0. The next step clears stalled with period_valid=0. Assert reset_n=0 mid-filter -> all outputs 0 immediately.

Source files
------------

// File: rtl/hall_conditioner.sv
// -----------------------------------------------------------------------------
// hall_conditioner
//   Conditions the three raw Hall inputs of one BLDC motor. It synchronizes
//   them, optionally glitch-filters them, and rejects the illegal codes 000
//   and 111. It tracks direction and a signed position count, and measures
//   the commutation period in clock cycles.
//
//   Optional feature macro: HALL_FILTER_EN
//     defined   -> a new code must be stable for FILTER_CYCLES clocks before
//                  it is accepted (raw-to-output latency FILTER_CYCLES+3)
//     undefined -> every change of the synchronized code is accepted on the
//                  next edge (latency 3); FILTER_CYCLES is ignored
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   hall_raw      in   [2:0] unsynchronized Hall pins {C,B,A}
//   hall          out  [2:0] last accepted legal code (to phase driver)
//   hall_valid    out  hall is legal and current (not faulted)
//   hall_fault    out  last accepted code was 000 or 111
//   step          out  one-clock pulse on an adjacent legal transition
//   skip          out  one-clock pulse on a non-adjacent legal transition
//   dir           out  1 = forward, 0 = reverse (direction of last step)
//   position      out  [COUNT_WIDTH-1:0] signed step count, wraps
//   period        out  [PERIOD_WIDTH-1:0] clocks between the last two steps
//   period_valid  out  period holds a real measurement
//   stalled       out  step-interval counter saturated
// -----------------------------------------------------------------------------
module hall_conditioner #(
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2:0]              hall_raw,
  output logic [2:0]              hall,
  output logic                    hall_valid,
  output logic                    hall_fault,
  output logic                    step,
  output logic                    skip,
  output logic                    dir,
  output logic [COUNT_WIDTH-1:0]  position,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Position of a code in the forward cycle 001,011,010,110,100,101;
  // 7 marks an illegal code.
  function automatic logic [2:0] hall_index(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b001:  idx = 3'd0;
      3'b011:  idx = 3'd1;
      3'b010:  idx = 3'd2;
      3'b110:  idx = 3'd3;
      3'b100:  idx = 3'd4;
      3'b101:  idx = 3'd5;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] fwd_index(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] rev_index(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  endfunction

  logic [2:0] meta_r;
  logic [2:0] sync_r;
  logic       accept_s;
  logic [2:0] acc_code_s;

  // Two-flop synchronizer on the raw pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 3'b000;
      sync_r <= 3'b000;
    end else begin
      meta_r <= hall_raw;
      sync_r <= meta_r;
    end
  end

`ifdef HALL_FILTER_EN
  // Out-of-range settings are clamped into 1..255.
  localparam int FC = (FILTER_CYCLES < 1) ? 1 :
                      ((FILTER_CYCLES > 255) ? 255 : FILTER_CYCLES);
  localparam logic [7:0] FC_LAST = 8'(FC - 1);
  localparam logic [7:0] FC_MAX  = 8'(FC);

  logic [2:0] cand_r;
  logic [7:0] stable_r;

  // Candidate tracker: reload on any change, otherwise count up and hold
  // at FC so an unchanged code is accepted exactly once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_r   <= 3'b000;
      stable_r <= 8'd0;
    end else if (sync_r != cand_r) begin
      cand_r   <= sync_r;
      stable_r <= 8'd0;
    end else if (stable_r != FC_MAX) begin
      stable_r <= stable_r + 8'd1;
    end else begin
      stable_r <= stable_r;
    end
  end

  // The count reads FC-1 on the FC-th consecutive stable clock.
  assign accept_s   = (sync_r == cand_r) && (stable_r == FC_LAST);
  assign acc_code_s = cand_r;
`else
  logic [2:0] prev_r;

  // Previous synchronized code, used for change detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= 3'b000;
    end else begin
      prev_r <= sync_r;
    end
  end

  assign accept_s   = (sync_r != prev_r);
  assign acc_code_s = sync_r;
`endif

  logic [2:0] new_idx_s;
  logic [2:0] old_idx_s;
  logic       legal_s;
  logic       is_fwd_s;
  logic       is_rev_s;
  logic       is_same_s;

  // Classify the accepted code relative to the current hall code.
  always_comb begin
    new_idx_s = hall_index(acc_code_s);
    old_idx_s = hall_index(hall);
    legal_s   = (new_idx_s != 3'd7);
    is_fwd_s  = legal_s && (new_idx_s == fwd_index(old_idx_s));
    is_rev_s  = legal_s && (new_idx_s == rev_index(old_idx_s));
    is_same_s = legal_s && (new_idx_s == old_idx_s);
  end

  logic [1:0]              state_r;
  logic [PERIOD_WIDTH-1:0] interval_r;
  logic                    have_step_r;

  // Direction/position FSM and step-period measurement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_INIT;
      hall         <= 3'b000;
      hall_valid   <= 1'b0;
      hall_fault   <= 1'b0;
      step         <= 1'b0;
      skip         <= 1'b0;
      dir          <= 1'b0;
      position     <= {COUNT_WIDTH{1'b0}};
      period       <= {PERIOD_WIDTH{1'b0}};
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      interval_r   <= {PERIOD_WIDTH{1'b0}};
      have_step_r  <= 1'b0;
    end else begin
      step <= 1'b0;
      skip <= 1'b0;
      case (state_r)
        ST_INIT, ST_FAULT: begin
          if (accept_s && legal_s) begin
            // (Re)load without a step; a new measurement episode starts.
            state_r      <= ST_TRACK;
            hall         <= acc_code_s;
            hall_valid   <= 1'b1;
            hall_fault   <= 1'b0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            interval_r   <= {PERIOD_WIDTH{1'b0}};
            have_step_r  <= 1'b0;
          end else if (accept_s) begin
            state_r      <= ST_FAULT;
            hall_fault   <= 1'b1;
            hall_valid   <= 1'b0;
            period_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_TRACK: begin
          if (accept_s && !legal_s) begin
            state_r      <= ST_FAULT;
            hall_fault   <= 1'b1;
            hall_valid   <= 1'b0;
            period_valid <= 1'b0;
          end else if (accept_s && (is_fwd_s || is_rev_s)) begin
            step         <= 1'b1;
            dir          <= is_fwd_s;
            position     <= is_fwd_s ? (position + COUNT_ONE) : (position - COUNT_ONE);
            hall         <= acc_code_s;
            // A saturated counter cannot be incremented; report full scale.
            period       <= (interval_r == PERIOD_MAX) ? PERIOD_MAX : (interval_r + PERIOD_ONE);
            period_valid <= have_step_r && (interval_r != PERIOD_MAX);
            stalled      <= 1'b0;
            interval_r   <= {PERIOD_WIDTH{1'b0}};
            have_step_r  <= 1'b1;
          end else if (accept_s && !is_same_s) begin
            // Lost steps: the next step cannot be a clean measurement.
            skip         <= 1'b1;
            hall         <= acc_code_s;
            period_valid <= 1'b0;
            interval_r   <= {PERIOD_WIDTH{1'b0}};
            have_step_r  <= 1'b0;
          end else if (interval_r >= (PERIOD_MAX - PERIOD_ONE)) begin
            interval_r   <= PERIOD_MAX;
            stalled      <= 1'b1;
            period_valid <= 1'b0;
          end else begin
            interval_r <= interval_r + PERIOD_ONE;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_conditioner.sv
// -----------------------------------------------------------------------------
// tb_hall_conditioner
//   Directed bench for hall_conditioner. u_dut uses default widths; u_dut8
//   uses an 8-bit period counter to exercise saturation quickly.
// -----------------------------------------------------------------------------
module tb_hall_conditioner;

`ifdef HALL_FILTER_EN
  localparam int LAT = 16 + 3;
  localparam logic [31:0] PULSE_STEP1 = 32'd0;
  localparam logic [31:0] PULSE_POS1  = 32'd6;
  localparam logic [31:0] PULSE_HALL1 = 32'h1;
  localparam logic [31:0] PULSE_STEP2 = 32'd0;
  localparam logic [31:0] PULSE_DIR2  = 32'd1;
`else
  localparam int LAT = 3;
  localparam logic [31:0] PULSE_STEP1 = 32'd1;
  localparam logic [31:0] PULSE_POS1  = 32'd7;
  localparam logic [31:0] PULSE_HALL1 = 32'h3;
  localparam logic [31:0] PULSE_STEP2 = 32'd1;
  localparam logic [31:0] PULSE_DIR2  = 32'd0;
`endif

  logic        clock;
  logic        reset_n;
  logic [2:0]  hall_raw;
  logic [2:0]  hall;
  logic        hall_valid, hall_fault, step, skip, dir;
  logic [15:0] position;
  logic [15:0] period;
  logic        period_valid, stalled;

  logic [2:0]  hall_raw8;
  logic [2:0]  hall8;
  logic        hall_valid8, hall_fault8, step8, skip8, dir8;
  logic [15:0] position8;
  logic [7:0]  period8;
  logic        period_valid8, stalled8;

  int total = 0;
  int bad   = 0;

  hall_conditioner #(.FILTER_CYCLES(16), .PERIOD_WIDTH(16), .COUNT_WIDTH(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw),
    .hall(hall), .hall_valid(hall_valid), .hall_fault(hall_fault),
    .step(step), .skip(skip), .dir(dir), .position(position),
    .period(period), .period_valid(period_valid), .stalled(stalled)
  );

  hall_conditioner #(.FILTER_CYCLES(16), .PERIOD_WIDTH(8), .COUNT_WIDTH(16)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw8),
    .hall(hall8), .hall_valid(hall_valid8), .hall_fault(hall_fault8),
    .step(step8), .skip(skip8), .dir(dir8), .position(position8),
    .period(period8), .period_valid(period_valid8), .stalled(stalled8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [2:0] fwd_seq [6];
    fwd_seq[0] = 3'b011; fwd_seq[1] = 3'b010; fwd_seq[2] = 3'b110;
    fwd_seq[3] = 3'b100; fwd_seq[4] = 3'b101; fwd_seq[5] = 3'b001;

    // Reset state
    reset_n   = 1'b0;
    hall_raw  = 3'b000;
    hall_raw8 = 3'b000;
    wait_neg(3);
    chk("reset_hall", 32'(hall), 32'h0);
    chk("reset_valid", 32'(hall_valid), 32'd0);
    chk("reset_position", 32'(position), 32'd0);
    chk("reset_period_valid", 32'(period_valid), 32'd0);

    // First legal code: load, no step, exact latency
    reset_n  = 1'b1;
    hall_raw = 3'b001;
    wait_neg(LAT - 1);
    chk("init_before_latency", 32'(hall_valid), 32'd0);
    wait_neg(1);
    chk("init_hall", 32'(hall), 32'h1);
    chk("init_valid", 32'(hall_valid), 32'd1);
    chk("init_step", 32'(step), 32'd0);
    chk("init_position", 32'(position), 32'd0);

    // Forward revolution at 10000-clock intervals
    for (int i = 0; i < 6; i++) begin
      hall_raw = fwd_seq[i];
      wait_neg(LAT);
      chk("fwd_step", 32'(step), 32'd1);
      chk("fwd_dir", 32'(dir), 32'd1);
      chk("fwd_position", 32'(position), 32'(i + 1));
      if (i == 0) begin
        chk("fwd_first_period_valid", 32'(period_valid), 32'd0);
      end else begin
        chk("fwd_period", 32'(period), 32'd10000);
        chk("fwd_period_valid", 32'(period_valid), 32'd1);
      end
      wait_neg(1);
      chk("fwd_step_pulse_width", 32'(step), 32'd0);
      wait_neg(10000 - LAT - 1);
    end

    // Reversal from 011: 001 then 101, steps 20 clocks apart
    hall_raw = 3'b011;
    wait_neg(LAT);
    chk("rev_setup_position", 32'(position), 32'd7);
    wait_neg(20 - LAT);
    hall_raw = 3'b001;
    wait_neg(LAT);
    chk("rev1_step", 32'(step), 32'd1);
    chk("rev1_dir", 32'(dir), 32'd0);
    chk("rev1_position", 32'(position), 32'd6);
    chk("rev1_period", 32'(period), 32'd20);
    chk("rev1_period_valid", 32'(period_valid), 32'd1);
    wait_neg(20 - LAT);
    hall_raw = 3'b101;
    wait_neg(LAT);
    chk("rev2_dir", 32'(dir), 32'd0);
    chk("rev2_position", 32'(position), 32'd5);
    wait_neg(20 - LAT);

    // Back to 001, then a 5-clock pulse to 011
    hall_raw = 3'b001;
    wait_neg(LAT);
    chk("pulse_setup_position", 32'(position), 32'd6);
    wait_neg(20);
    hall_raw = 3'b011;
    wait_neg(3);
    chk("pulse_step_a", 32'(step), PULSE_STEP1);
    chk("pulse_position_a", 32'(position), PULSE_POS1);
    chk("pulse_hall_a", 32'(hall), PULSE_HALL1);
    wait_neg(2);
    hall_raw = 3'b001;
    wait_neg(3);
    chk("pulse_step_b", 32'(step), PULSE_STEP2);
    chk("pulse_dir_b", 32'(dir), PULSE_DIR2);
    wait_neg(LAT + 5);
    chk("pulse_final_hall", 32'(hall), 32'h1);
    chk("pulse_final_position", 32'(position), 32'd6);

    // Walk to 010, then an illegal code
    hall_raw = 3'b011;
    wait_neg(LAT + 10);
    hall_raw = 3'b010;
    wait_neg(LAT + 10);
    chk("fault_setup_position", 32'(position), 32'd8);
    hall_raw = 3'b111;
    wait_neg(LAT);
    chk("fault_flag", 32'(hall_fault), 32'd1);
    chk("fault_valid", 32'(hall_valid), 32'd0);
    chk("fault_hall_kept", 32'(hall), 32'h2);
    chk("fault_period_valid", 32'(period_valid), 32'd0);
    wait_neg(10);
    hall_raw = 3'b110;
    wait_neg(LAT);
    chk("recover_hall", 32'(hall), 32'h6);
    chk("recover_valid", 32'(hall_valid), 32'd1);
    chk("recover_fault", 32'(hall_fault), 32'd0);
    chk("recover_step", 32'(step), 32'd0);
    chk("recover_position", 32'(position), 32'd8);
    wait_neg(10);

    // Distance-2 jump 110 -> 101 is a skip
    hall_raw = 3'b101;
    wait_neg(LAT);
    chk("skip_pulse", 32'(skip), 32'd1);
    chk("skip_no_step", 32'(step), 32'd0);
    chk("skip_hall", 32'(hall), 32'h5);
    chk("skip_position", 32'(position), 32'd8);
    chk("skip_dir", 32'(dir), 32'd1);

    // 8-bit period counter: saturation and stall
    hall_raw8 = 3'b001;
    wait_neg(LAT);
    chk("sat_loaded", 32'(hall_valid8), 32'd1);
    wait_neg(254);
    chk("sat_not_yet", 32'(stalled8), 32'd0);
    wait_neg(1);
    chk("sat_stalled", 32'(stalled8), 32'd1);
    chk("sat_period_valid", 32'(period_valid8), 32'd0);
    wait_neg(45);
    chk("sat_still_stalled", 32'(stalled8), 32'd1);
    hall_raw8 = 3'b011;
    wait_neg(LAT);
    chk("sat_step", 32'(step8), 32'd1);
    chk("sat_stall_cleared", 32'(stalled8), 32'd0);
    chk("sat_step_period_valid", 32'(period_valid8), 32'd0);
    wait_neg(50 - LAT);
    hall_raw8 = 3'b010;
    wait_neg(LAT);
    chk("sat_next_period", 32'(period8), 32'd50);
    chk("sat_next_period_valid", 32'(period_valid8), 32'd1);

    // Asynchronous reset while a new code is in the filter
    hall_raw  = 3'b100;
    hall_raw8 = 3'b110;
    @(negedge clock);
    #7;
    reset_n = 1'b0;
    #1;
    chk("areset_hall", 32'(hall), 32'h0);
    chk("areset_flags", 32'({hall_valid, hall_fault, step, skip, dir, period_valid, stalled}), 32'h0);
    chk("areset_position", 32'(position), 32'd0);
    chk("areset_period", 32'(period), 32'd0);
    chk("areset8_hall", 32'(hall8), 32'h0);
    chk("areset8_flags", 32'({hall_valid8, hall_fault8, step8, skip8, dir8, period_valid8, stalled8}), 32'h0);
    chk("areset8_position", 32'(position8), 32'd0);
    chk("areset8_period", 32'(period8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
